prll_bs_rr_arbiter: RTL and testbench
=====================================

// Module: prll_bs_rr_arbiter
// PURPOSE
//  Round-robin controller for the single-bus parallel bus generator: grants one pending driver FIFO
//  at a time, pops its head word, and pushes it to the addressed driver(s) or to all others on broadcast.
//  Sits between the per-driver FIFOs (pndng/pop/D_pop) and the receive FIFOs (push/D_push).
// PARAMETERS
//  bits      256    width of one bus word; destination ID in D_pop[bits-1 -: 8]
//  drvrs     4      number of drivers on the bus (2..8)
//  broadcast 8'hFF  destination ID meaning "deliver to every driver except the source"
// PORTS
//  clk      in   1            bus clock, all logic rising-edge
//  reset    in   1            asynchronous, active-low; clears all state
//  pndng    in   drvrs        bit i: driver i FIFO non-empty, head word valid on D_pop slice i
//  D_pop    in   drvrs*bits   head words, slice i = D_pop[i*bits +: bits]
//  pop      out  drvrs        one-hot, 1-cycle pop strobe to granted driver
//  push     out  drvrs        1-cycle push strobes to destination driver(s)
//  D_push   out  drvrs*bits   word delivered, identical in every slice
//  busy     out  1            high in any state other than IDLE
//  drop_cnt out  16           saturating count of undeliverable words
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, last_grant=drvrs-1, data reg=0, pop=push=0, D_push=0, busy=0, drop_cnt=0.
//  FSM, Moore outputs, one transaction = 3 cycles, no back-to-back overlap:
//   IDLE : if |pndng, grant g = first set bit searching last_grant+1, +2, ... with wrap modulo drvrs;
//          register g, last_grant<=g, go POP. Else stay.
//   POP  : pop[g]=1 for this cycle only; latch D_pop slice g into data reg; decode dest=data[bits-1 -: 8];
//          go PUSH.
//   PUSH : D_push slices=data reg; push mask asserted for this cycle only:
//          dest==broadcast -> all bits except g; dest<drvrs and dest!=g -> bit dest only;
//          dest>=drvrs (non-broadcast) or dest==g -> mask 0, drop_cnt+=1 (saturates at 16'hFFFF).
//          Go IDLE.
//  Latency: pndng high in cycle N (IDLE) -> pop in N+1 -> push in N+2; next grant decision in N+3.
//  Fairness: a driver holding pndng continuously is granted at most once per drvrs transactions
//   while others are pending; a lone requester is served every 3 cycles.
//  pndng changes during POP/PUSH are ignored; only IDLE samples pndng.
//  D_push holds last delivered word until the next PUSH (value not meaningful when push=0).
//  Reset asserted mid-transaction: outputs drop to 0 asynchronously; the latched word is lost and not
//   counted; the source FIFO entry is consumed if pop had already fired.
//  No push back-pressure: receive FIFOs are required to accept every push.
// STRUCTURE
//  Package prll_bs_pkg: state enum {IDLE,POP,PUSH} (2 bits), ID_W=8, localparam DROP_W=16.
//  Sub-module rr_prio_enc #(N): req[N], last[$clog2(N)] -> gnt_idx, gnt_vld; pure combinational.
//  Top: FSM, grant/last_grant regs, data reg, push-mask decode, drop counter.
// TESTING
//  1 Reset: hold reset=0, toggle pndng=4'hF -> pop,push,busy,drop_cnt all 0; release -> first pop=4'b0001.
//  2 Unicast: pndng=4'b0100, D_pop2 dest=8'h01 payload 'hA5 -> pop=0100 at N+1, push=0010 at N+2, D_push='hA5.
//  3 Broadcast: driver 1 sends dest=8'hFF -> push=4'b1101 one cycle; drop_cnt unchanged.
//  4 Round-robin: pndng=4'hF held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; busy low 1 of every 3 cycles.
//  5 Drops: dest=8'h07 from driver 0 and dest=8'h00 from driver 0 -> push=0 both, drop_cnt=2; preload 16'hFFFE,
//    three drops -> stays 16'hFFFF.
//  6 Mid-op reset: assert reset during PUSH -> push=0 immediately; after release pndng=4'b1000 -> pop=4'b0001? no:
//    pop=4'b1000 (last_grant reset to 3, search from 0 wraps to 3).

Source files
------------

// File: rtl/prll_bs_pkg.sv
// Shared types and constants for the parallel-bus round-robin controller.
//   state_e : controller FSM states (IDLE -> POP -> PUSH -> IDLE)
//   ID_W    : width of the destination ID at the top of each bus word
//   DROP_W  : width of the undeliverable-word counter
//   sat_inc : saturating increment used by the drop counter
package prll_bs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  localparam int ID_W   = 8;
  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder (purely combinational).
// Searches req starting one position after 'last' and wrapping modulo N;
// the first set bit found is the grant.
//   req     in  N      request vector
//   last    in  IDX_W  index granted most recently
//   gnt_idx out IDX_W  index of the winning request (0 when none)
//   gnt_vld out 1      at least one request is set
module rr_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] idx;

  // Walk the search order from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prll_bs_rr_arbiter.sv
// Round-robin controller for a single-bus parallel bus generator.
// Grants one pending driver FIFO at a time, pops its head word and pushes it
// to the addressed driver, or to every other driver on broadcast.
// One transaction takes three cycles (IDLE, POP, PUSH) with no overlap.
//   clk      in  1            rising-edge clock
//   reset    in  1            asynchronous, active-low
//   pndng    in  drvrs        driver FIFO non-empty flags
//   D_pop    in  drvrs*bits   driver FIFO head words, slice i = driver i
//   pop      out drvrs        one-hot pop strobe to the granted driver
//   push     out drvrs        push strobes to the destination driver(s)
//   D_push   out drvrs*bits   delivered word, replicated in every slice
//   busy     out 1            controller is mid-transaction
//   drop_cnt out 16           saturating count of undeliverable words
module prll_bs_rr_arbiter
  import prll_bs_pkg::*;
#(
  parameter int              bits      = 256,
  parameter int              drvrs     = 4,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [drvrs-1:0]        pndng,
  input  logic [drvrs*bits-1:0]   D_pop,
  output logic [drvrs-1:0]        pop,
  output logic [drvrs-1:0]        push,
  output logic [drvrs*bits-1:0]   D_push,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [bits-1:0]   data_q, data_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [GW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [drvrs-1:0]  mask;

  // Destination decode: broadcast reaches everyone but the source; a word
  // addressed to a missing driver or back to its own source goes nowhere.
  function automatic logic [drvrs-1:0] push_mask(input logic [ID_W-1:0] dest,
                                                 input logic [GW-1:0]   src);
    logic [drvrs-1:0] m;
    m = '0;
    if (dest == broadcast) begin
      m      = '1;
      m[src] = 1'b0;
    end else if ((int'(dest) < drvrs) && (dest != ID_W'(src))) begin
      m[dest[GW-1:0]] = 1'b1;
    end
    return m;
  endfunction

  rr_prio_enc #(
    .N     (drvrs),
    .IDX_W (GW)
  ) u_prio (
    .req     (pndng),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign mask = push_mask(data_q[bits-1 -: ID_W], grant_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant_d = gnt_idx;
          last_d  = gnt_idx;
          state_d = POP;
        end
      end
      POP: begin
        data_d  = D_pop[grant_q*bits +: bits];
        state_d = PUSH;
      end
      PUSH: begin
        if (mask == '0) drop_cnt_d = sat_inc(drop_cnt_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(drvrs - 1);
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Moore outputs: strobes depend only on registered state, so an
  // asynchronous reset clears them immediately.
  always_comb begin
    pop  = '0;
    push = '0;
    if (state_q == POP)  pop[grant_q] = 1'b1;
    if (state_q == PUSH) push = mask;
  end

  assign busy     = (state_q != IDLE);
  assign D_push   = {drvrs{data_q}};
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_prll_bs_rr_arbiter.sv
module tb_prll_bs_rr_arbiter;

  localparam int BITS = 256;
  localparam int NDRV = 4;

  logic                 clk;
  logic                 reset;
  logic [NDRV-1:0]      pndng;
  logic [NDRV*BITS-1:0] D_pop;
  logic [NDRV-1:0]      pop;
  logic [NDRV-1:0]      push;
  logic [NDRV*BITS-1:0] D_push;
  logic                 busy;
  logic [15:0]          drop_cnt;

  prll_bs_rr_arbiter #(
    .bits      (BITS),
    .drvrs     (NDRV),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_push;
    logic [NDRV-1:0] vec;
    logic [BITS-1:0] data;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_evt(input bit is_push, input logic [NDRV-1:0] vec,
                         input logic [NDRV*BITS-1:0] d);
    exp_t e;
    bit   ok;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_%s: got vec=%b at cycle %0d expected no strobe",
               is_push ? "push" : "pop", vec, cyc);
    end else begin
      e  = sb.pop_front();
      ok = (e.is_push == is_push) && (e.vec === vec) && (e.cyc == cyc);
      if (is_push && (d !== {NDRV{e.data}})) ok = 1'b0;
      if (!ok) begin
        mismatched++;
        $display("FAIL %s_evt: got vec=%b cyc=%0d data=%h expected %s vec=%b cyc=%0d data=%h",
                 is_push ? "push" : "pop", vec, cyc, d[BITS-1:0],
                 e.is_push ? "push" : "pop", e.vec, e.cyc, e.data);
      end
    end
  endtask

  // Output monitor: every strobe the DUT presents is matched against the
  // head of the scoreboard.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (reset) begin
        if (pop  != '0) mon_evt(1'b0, pop,  '0);
        if (push != '0) mon_evt(1'b1, push, D_push);
      end
    end
  endtask

  function automatic logic [BITS-1:0] mk_word(input int g, input logic [7:0] dest,
                                              input logic [7:0] pay);
    logic [BITS-1:0] w;
    w = '0;
    w[BITS-1 -: 8] = dest;
    w[15:8]        = 8'(g);
    w[7:0]         = pay;
    return w;
  endfunction

  // Issue one transaction from an IDLE negedge; returns at the next IDLE negedge.
  task automatic txn(input logic [NDRV-1:0] pv, input int g, input logic [7:0] dest,
                     input logic [7:0] pay, input logic [NDRV-1:0] mask);
    logic [BITS-1:0] w;
    w = mk_word(g, dest, pay);
    pndng = pv;
    D_pop[g*BITS +: BITS] = w;
    sb.push_back('{1'b0, NDRV'(1 << g), '0, cyc + 1});
    if (mask != '0) sb.push_back('{1'b1, mask, w, cyc + 2});
    check("busy_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_pop", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_push", 32'(busy), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [BITS-1:0] w6;
    fork
      monitor_loop();
    join_none

    // Reset held with all drivers pending
    reset = 1'b0;
    pndng = 4'hF;
    D_pop = '0;
    repeat (3) @(negedge clk);
    check("rst_pop",  32'(pop),      32'd0);
    check("rst_push", 32'(push),     32'd0);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;
    txn(4'hF, 0, 8'h01, 8'h11, 4'b0010);

    // Unicast and broadcast
    txn(4'b0100, 2, 8'h01, 8'hA5, 4'b0010);
    txn(4'b0010, 1, 8'hFF, 8'h5A, 4'b1101);
    check("bcast_drop", 32'(drop_cnt), 32'd0);

    // Move last grant to driver 3, then round-robin with everyone pending
    txn(4'b1000, 3, 8'h00, 8'h33, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      txn(4'hF, i % 4, 8'((i % 4 + 1) % 4), 8'(8'h40 + i), NDRV'(1 << ((i % 4 + 1) % 4)));
    end
    check("rr_drop", 32'(drop_cnt), 32'd0);

    // Undeliverable words
    txn(4'b0001, 0, 8'h07, 8'hD0, 4'b0000);
    check("drop_1", 32'(drop_cnt), 32'd1);
    txn(4'b0001, 0, 8'h00, 8'hD1, 4'b0000);
    check("drop_2", 32'(drop_cnt), 32'd2);

    // Saturation from a preloaded counter
    pndng = '0;
    force dut.drop_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.drop_cnt_q;
    check("drop_preload", 32'(drop_cnt), 32'hFFFE);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      txn(4'b0001, 0, 8'h09, 8'(8'hE0 + i), 4'b0000);
      check("drop_sat", 32'(drop_cnt), 32'hFFFF);
    end

    // Reset during PUSH
    pndng = 4'b0001;
    w6 = mk_word(0, 8'h02, 8'h66);
    D_pop[0 +: BITS] = w6;
    sb.push_back('{1'b0, 4'b0001, '0, cyc + 1});
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_push", 32'(push),     32'd0);
    check("midrst_pop",  32'(pop),      32'd0);
    check("midrst_busy", 32'(busy),     32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    pndng = 4'b1000;
    @(negedge clk);
    reset = 1'b1;
    txn(4'b1000, 3, 8'h01, 8'h77, 4'b0010);

    pndng = '0;
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
